// File: rtl/inst_loader_pkg.sv
// rtl/inst_loader_pkg.sv - shared constants, FSM encoding and address helper for inst_loader
//
// Purpose: single home for instruction-memory geometry, the loader state
// encoding and the word-index to byte-address mapping.
package inst_loader_pkg;

  localparam int INST_ADDR_WIDTH     = 16;  // byte address width of instruction memory
  localparam int INST_DATA_BIT_WIDTH = 16;  // instruction word width
  localparam int INST_MEM_SIZE       = 26;  // capacity in instruction words
  localparam int NUM_BYTES_IN_INST   = 2;   // byte address step per word
  localparam int LEN_WIDTH           = 8;   // width of the word-count input
  localparam int BYTE_WIDTH          = 8;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RECV_HI = 3'd1;
  localparam logic [2:0] ST_RECV_LO = 3'd2;
  localparam logic [2:0] ST_WRITE   = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  // Byte address of instruction word number cnt.
  function automatic logic [INST_ADDR_WIDTH-1:0] word_addr(input logic [LEN_WIDTH-1:0] cnt);
    logic [INST_ADDR_WIDTH-1:0] a;
    a = INST_ADDR_WIDTH'(cnt);
    return a * INST_ADDR_WIDTH'(NUM_BYTES_IN_INST);
  endfunction

  // A load length is usable only if it is non-zero and fits in memory.
  function automatic logic len_ok(input logic [LEN_WIDTH-1:0] len);
    return (len != '0) && (len <= LEN_WIDTH'(INST_MEM_SIZE));
  endfunction

endpackage

// File: rtl/inst_loader_word_packer.sv
// rtl/inst_loader_word_packer.sv - captures high and low bytes and presents the packed word
//
// Ports:
//   clk_i    in   clock
//   rst_ni   in   asynchronous active-low reset, clears both bytes
//   hi_we_i  in   capture byte_i as the high byte
//   lo_we_i  in   capture byte_i as the low byte
//   byte_i   in   incoming stream byte
//   word_o   out  {hi, lo}
module inst_loader_word_packer
  import inst_loader_pkg::*;
(
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           hi_we_i,
  input  logic                           lo_we_i,
  input  logic [BYTE_WIDTH-1:0]          byte_i,
  output logic [INST_DATA_BIT_WIDTH-1:0] word_o
);

  logic [BYTE_WIDTH-1:0] hi_q, hi_d;
  logic [BYTE_WIDTH-1:0] lo_q, lo_d;

  always_comb begin
    hi_d = hi_we_i ? byte_i : hi_q;
    lo_d = lo_we_i ? byte_i : lo_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign word_o = {hi_q, lo_q};

endmodule

// File: rtl/inst_loader.sv
// rtl/inst_loader.sv - loads a byte-streamed program into instruction memory while holding the CPU
//
// Ports:
//   clk_i       in   clock, all state on rising edge
//   rst_ni      in   asynchronous active-low reset
//   start_i     in   load request, honoured only in IDLE or DONE
//   load_len_i  in   number of words to load, sampled with start_i
//   in_valid_i  in   byte-stream valid
//   in_byte_i   in   byte-stream data, high byte of each word first
//   in_ready_o  out  byte accepted when in_valid_i & in_ready_o
//   wr_en_o     out  instruction-memory write strobe (one cycle per word)
//   wr_addr_o   out  byte address of the write
//   wr_data_o   out  {hi, lo} word being written
//   cpu_hold_o  out  1 = CPU held in reset
//   done_o      out  load complete
//   err_o       out  last start carried an unusable length
module inst_loader
  import inst_loader_pkg::*;
(
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           start_i,
  input  logic [LEN_WIDTH-1:0]           load_len_i,
  input  logic                           in_valid_i,
  input  logic [BYTE_WIDTH-1:0]          in_byte_i,
  output logic                           in_ready_o,
  output logic                           wr_en_o,
  output logic [INST_ADDR_WIDTH-1:0]     wr_addr_o,
  output logic [INST_DATA_BIT_WIDTH-1:0] wr_data_o,
  output logic                           cpu_hold_o,
  output logic                           done_o,
  output logic                           err_o
);

  logic [2:0]                 state_q, state_d;
  logic [LEN_WIDTH-1:0]       len_q, len_d;
  logic [LEN_WIDTH-1:0]       cnt_q, cnt_d;
  logic                       wr_en_q, wr_en_d;
  logic [INST_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic                       cpu_hold_q, cpu_hold_d;
  logic                       done_q, done_d;
  logic                       err_q, err_d;
  logic                       handshake;
  logic                       hi_we;
  logic                       lo_we;

  assign in_ready_o = (state_q == ST_RECV_HI) || (state_q == ST_RECV_LO);
  assign handshake  = in_valid_i & in_ready_o;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    cpu_hold_d = cpu_hold_q;
    done_d     = done_q;
    err_d      = err_q;
    hi_we      = 1'b0;
    lo_we      = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          if (!len_ok(load_len_i)) begin
            err_d = 1'b1;
          end else begin
            len_d      = load_len_i;
            cnt_d      = '0;
            err_d      = 1'b0;
            done_d     = 1'b0;
            cpu_hold_d = 1'b1;
            state_d    = ST_RECV_HI;
          end
        end
      end
      ST_RECV_HI: begin
        if (handshake) begin
          hi_we   = 1'b1;
          state_d = ST_RECV_LO;
        end
      end
      ST_RECV_LO: begin
        // Strobe and address are registered here so they appear during WRITE,
        // together with the packer output that captures the low byte on this edge.
        if (handshake) begin
          lo_we     = 1'b1;
          wr_en_d   = 1'b1;
          wr_addr_d = word_addr(cnt_q);
          state_d   = ST_WRITE;
        end
      end
      ST_WRITE: begin
        cnt_d = cnt_q + 1'b1;
        if ((cnt_q + 1'b1) == len_q) begin
          done_d     = 1'b1;
          cpu_hold_d = 1'b0;
          state_d    = ST_DONE;
        end else begin
          state_d = ST_RECV_HI;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      cpu_hold_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  inst_loader_word_packer u_packer (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .hi_we_i (hi_we),
    .lo_we_i (lo_we),
    .byte_i  (in_byte_i),
    .word_o  (wr_data_o)
  );

  assign wr_en_o    = wr_en_q;
  assign wr_addr_o  = wr_addr_q;
  assign cpu_hold_o = cpu_hold_q;
  assign done_o     = done_q;
  assign err_o      = err_q;

endmodule
